// File: rtl/apb_i2c_pkg.sv
// Shared constants and FSM state type for the APB register interface of the I2C controller.
package apb_i2c_pkg;

    localparam logic [7:0] ADDR_TXDATA  = 8'h00;
    localparam logic [7:0] ADDR_RXDATA  = 8'h04;
    localparam logic [7:0] ADDR_CONFIG  = 8'h08;
    localparam logic [7:0] ADDR_TIMEOUT = 8'h0C;
    localparam logic [7:0] ADDR_STATUS  = 8'h10;
    localparam logic [7:0] ADDR_INTEN   = 8'h14;
    localparam logic [7:0] ADDR_INTSTAT = 8'h18;

    localparam int unsigned INT_W        = 4;
    localparam int unsigned INT_TX_EMPTY = 0;
    localparam int unsigned INT_RX_AVAIL = 1;
    localparam int unsigned INT_CORE_ERR = 2;
    localparam int unsigned INT_TX_TMO   = 3;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RX_POP,
        RX_DATA,
        DONE
    } state_t;

endpackage

// File: rtl/apb_i2c_irq.sv
// Interrupt block: edge detectors, sticky W1C status, enable mask and interrupt outputs.
module apb_i2c_irq
    import apb_i2c_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_empty,
    input  logic             rx_empty,
    input  logic             core_error,
    input  logic             tmo_evt,
    input  logic             en_we,
    input  logic             stat_we,
    input  logic [INT_W-1:0] wdata,
    output logic [INT_W-1:0] int_en,
    output logic [INT_W-1:0] int_stat,
    output logic             irq,
    output logic             int_tx,
    output logic             int_rx
);

    logic             tx_empty_q;
    logic             rx_empty_q;
    logic             err_q;
    logic [INT_W-1:0] set_evt;
    logic [INT_W-1:0] clr_mask;

    always_comb begin
        set_evt               = '0;
        set_evt[INT_TX_EMPTY] = tx_empty & ~tx_empty_q;
        set_evt[INT_RX_AVAIL] = ~rx_empty & rx_empty_q;
        set_evt[INT_CORE_ERR] = core_error & ~err_q;
        set_evt[INT_TX_TMO]   = tmo_evt;
        clr_mask              = stat_we ? wdata : '0;
    end

    // Set is OR-ed after the clear so a same-cycle event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_empty_q <= 1'b1;
            rx_empty_q <= 1'b1;
            err_q      <= 1'b0;
            int_en     <= '0;
            int_stat   <= '0;
        end else begin
            tx_empty_q <= tx_empty;
            rx_empty_q <= rx_empty;
            err_q      <= core_error;
            if (en_we)
                int_en <= wdata;
            int_stat <= (int_stat & ~clr_mask) | set_evt;
        end
    end

    assign irq    = |(int_stat & int_en);
    assign int_tx = int_stat[INT_TX_EMPTY] & int_en[INT_TX_EMPTY];
    assign int_rx = int_stat[INT_RX_AVAIL] & int_en[INT_RX_AVAIL];

endmodule

// File: rtl/apb_i2c_csr.sv
// APB slave CSR block for the I2C controller: wait-stated FIFO ports, registered read data.
module apb_i2c_csr
    import apb_i2c_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned CFG_W    = 14,
    parameter int unsigned TMO_W    = 14,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_wdata,
    output logic              tx_wr_en,
    input  logic              tx_full,
    input  logic              tx_empty,
    input  logic [DATA_W-1:0] rx_rdata,
    output logic              rx_rd_en,
    input  logic              rx_empty,
    input  logic              core_error,
    output logic [CFG_W-1:0]  cfg,
    output logic [TMO_W-1:0]  timeout,
    output logic              int_tx,
    output logic              int_rx,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [INT_W-1:0] int_en;
    logic [INT_W-1:0] int_stat;
    logic             setup, in_access;
    logic             hit_tx, hit_rx, hit_cfg, hit_tmo, hit_stat, hit_en, hit_int, mapped;
    logic             tx_wait, tx_tmo, reg_we;
    logic [DATA_W-1:0] rd_mux;

    assign setup     = PSELx & ~PENABLE;
    assign in_access = (state == ACCESS) & PSELx & PENABLE;
    assign tx_wdata  = PWDATA;

    assign hit_tx   = PADDR == ADDR_W'(ADDR_TXDATA);
    assign hit_rx   = PADDR == ADDR_W'(ADDR_RXDATA);
    assign hit_cfg  = PADDR == ADDR_W'(ADDR_CONFIG);
    assign hit_tmo  = PADDR == ADDR_W'(ADDR_TIMEOUT);
    assign hit_stat = PADDR == ADDR_W'(ADDR_STATUS);
    assign hit_en   = PADDR == ADDR_W'(ADDR_INTEN);
    assign hit_int  = PADDR == ADDR_W'(ADDR_INTSTAT);
    assign mapped   = hit_tx | hit_rx | hit_cfg | hit_tmo | hit_stat | hit_en | hit_int;

    always_comb begin
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        tx_wr_en = 1'b0;
        rx_rd_en = 1'b0;
        tx_wait  = 1'b0;
        tx_tmo   = 1'b0;
        reg_we   = 1'b0;
        if (in_access) begin
            if (!mapped) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end else if (hit_tx && PWRITE) begin
                if (!tx_full) begin
                    PREADY   = 1'b1;
                    tx_wr_en = 1'b1;
                end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                    tx_tmo  = 1'b1;
                end else begin
                    tx_wait = 1'b1;
                end
            end else if (hit_rx && !PWRITE) begin
                if (rx_empty) begin
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                end else begin
                    rx_rd_en = 1'b1;
                end
            end else begin
                PREADY = 1'b1;
                reg_we = PWRITE;
            end
        end else if (state == RX_DATA && PSELx) begin
            PREADY = 1'b1;
        end
    end

    // Register reads are sampled in the setup phase so PRDATA is a flop when PREADY rises.
    always_comb begin
        rd_mux = '0;
        if (hit_cfg)       rd_mux = DATA_W'(cfg);
        else if (hit_tmo)  rd_mux = DATA_W'(timeout);
        else if (hit_stat) rd_mux = DATA_W'({core_error, rx_empty, tx_full, tx_empty});
        else if (hit_en)   rd_mux = DATA_W'(int_en);
        else if (hit_int)  rd_mux = DATA_W'(int_stat);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            PRDATA   <= '0;
            cfg      <= '0;
            timeout  <= '0;
        end else begin
            if (reg_we && hit_cfg)
                cfg <= PWDATA[CFG_W-1:0];
            if (reg_we && hit_tmo)
                timeout <= PWDATA[TMO_W-1:0];
            wait_cnt <= tx_wait ? wait_cnt + 1'b1 : '0;
            case (state)
                IDLE, DONE: begin
                    if (setup) begin
                        state  <= ACCESS;
                        PRDATA <= rd_mux;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!PSELx)        state <= IDLE;
                    else if (rx_rd_en) state <= RX_POP;
                    else if (PREADY)   state <= DONE;
                end
                RX_POP: begin
                    if (!PSELx) begin
                        state <= IDLE;
                    end else begin
                        state  <= RX_DATA;
                        PRDATA <= rx_rdata;
                    end
                end
                RX_DATA: state <= PSELx ? DONE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    apb_i2c_irq u_irq (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .tx_empty   (tx_empty),
        .rx_empty   (rx_empty),
        .core_error (core_error),
        .tmo_evt    (tx_tmo),
        .en_we      (reg_we & hit_en),
        .stat_we    (reg_we & hit_int),
        .wdata      (PWDATA[INT_W-1:0]),
        .int_en     (int_en),
        .int_stat   (int_stat),
        .irq        (irq),
        .int_tx     (int_tx),
        .int_rx     (int_rx)
    );

endmodule

// File: tb/tb_apb_i2c_csr.sv
// Self-checking bench for apb_i2c_csr: table of register accesses plus FIFO/IRQ/reset sequences.
module tb_apb_i2c_csr;

    logic        PCLK = 1'b0;
    logic        PRESETn, PSELx, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA, tx_wdata, rx_rdata;
    logic        PREADY, PSLVERR, tx_wr_en, tx_full, tx_empty, rx_rd_en, rx_empty, core_error;
    logic [13:0] cfg, timeout;
    logic        int_tx, int_rx, irq;

    int total = 0;
    int bad   = 0;
    int tx_pulses = 0;
    int rx_pulses = 0;
    logic [31:0] tx_last = '0;

    typedef struct {
        string       name;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        chk_rd;
        logic        err;
        int          cycles;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    apb_i2c_csr #(.DATA_W(32), .ADDR_W(8), .CFG_W(14), .TMO_W(14), .MAX_WAIT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_wdata(tx_wdata), .tx_wr_en(tx_wr_en), .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_rdata(rx_rdata), .rx_rd_en(rx_rd_en), .rx_empty(rx_empty), .core_error(core_error),
        .cfg(cfg), .timeout(timeout), .int_tx(int_tx), .int_rx(int_rx), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (tx_wr_en) begin
            tx_pulses++;
            tx_last = tx_wdata;
        end
        if (rx_rd_en) rx_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic wr, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic chk_rd, input logic err, input int cycles);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.chk_rd = chk_rd; v.err = err; v.cycles = cycles;
        return v;
    endfunction

    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int cycles);
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cycles = 2;
        @(negedge PCLK);
        while (!PREADY && cycles < 60) begin
            @(posedge PCLK); #1;
            @(negedge PCLK);
            cycles++;
        end
        if (!PREADY) begin
            bad++;
            total++;
            $display("FAIL apb_timeout: addr 0x%0h got no PREADY within %0d cycles", addr, cycles);
        end
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic run(input vec_t v);
        vec_t e;
        logic [31:0] rd;
        logic err;
        int cyc;
        sb.push_back(v);
        apb(v.wr, v.addr, v.wdata, rd, err, cyc);
        e = sb.pop_front();
        check({e.name, "_err"}, 32'(err), 32'(e.err));
        check({e.name, "_cyc"}, cyc, e.cycles);
        if (e.chk_rd) check({e.name, "_rd"}, rd, e.rdata);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; rx_rdata = '0;
        tx_full = 1'b0; tx_empty = 1'b1; rx_empty = 1'b1; core_error = 1'b0;
        #12;
        check("rst_pready", 32'(PREADY), 0);
        check("rst_pslverr", 32'(PSLVERR), 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_cfg", 32'(cfg), 0);
        check("rst_irq", {29'd0, irq, int_tx, int_rx}, 0);
        check("rst_pulses", {30'd0, tx_wr_en, rx_rd_en}, 0);
        @(posedge PCLK); #1 PRESETn = 1'b1;
        wait_cycles(2);

        tbl.push_back(mk("cfg_w",     1, 8'h08, 32'h0000_3FFF, 0, 0, 0, 2));
        tbl.push_back(mk("tmo_w",     1, 8'h0C, 32'h0000_0123, 0, 0, 0, 2));
        tbl.push_back(mk("cfg_r",     0, 8'h08, 0, 32'h0000_3FFF, 1, 0, 2));
        tbl.push_back(mk("tmo_r",     0, 8'h0C, 0, 32'h0000_0123, 1, 0, 2));
        tbl.push_back(mk("tmo_wide",  1, 8'h0C, 32'hFFFF_C555, 0, 0, 0, 2));
        tbl.push_back(mk("tmo_trunc", 0, 8'h0C, 0, 32'h0000_0555, 1, 0, 2));
        tbl.push_back(mk("stat_r",    0, 8'h10, 0, 32'h0000_0005, 1, 0, 2));
        tbl.push_back(mk("stat_w",    1, 8'h10, 32'hFFFF_FFFF, 0, 0, 0, 2));
        tbl.push_back(mk("stat_r2",   0, 8'h10, 0, 32'h0000_0005, 1, 0, 2));
        tbl.push_back(mk("txd_r",     0, 8'h00, 0, 32'h0, 1, 0, 2));
        tbl.push_back(mk("rxd_w",     1, 8'h04, 32'h1234_5678, 0, 0, 0, 2));
        tbl.push_back(mk("unmap_w",   1, 8'h1C, 32'h1, 0, 0, 1, 2));
        tbl.push_back(mk("unmap_r",   0, 8'h1C, 0, 0, 0, 1, 2));
        tbl.push_back(mk("unalign",   1, 8'h0A, 32'h1, 0, 0, 1, 2));
        tbl.push_back(mk("rx_empty",  0, 8'h04, 0, 32'h0, 1, 1, 2));
        tbl.push_back(mk("inten_w",   1, 8'h14, 32'hFFFF_FFFF, 0, 0, 0, 2));
        tbl.push_back(mk("inten_r",   0, 8'h14, 0, 32'h0000_000F, 1, 0, 2));
        tbl.push_back(mk("intst_r",   0, 8'h18, 0, 32'h0, 1, 0, 2));
        foreach (tbl[i]) run(tbl[i]);
        check("tbl_no_push", tx_pulses, 0);
        check("tbl_no_pop", rx_pulses, 0);
        check("cfg_port", 32'(cfg), 32'h3FFF);
        check("tmo_port", 32'(timeout), 32'h0555);

        // TX write stalled for three cycles by a full FIFO
        tx_full = 1'b1;
        fork
            run(mk("tx_wait", 1, 8'h00, 32'hCAFE_0042, 0, 0, 0, 5));
            begin
                wait (PSELx && PENABLE);
                repeat (3) @(posedge PCLK);
                #1 tx_full = 1'b0;
            end
        join
        check("tx_wait_pushes", tx_pulses, 1);
        check("tx_wait_wdata", tx_last, 32'hCAFE_0042);

        // TX write times out after MAX_WAIT wait states
        tx_full = 1'b1;
        run(mk("tx_tmo", 1, 8'h00, 32'h0BAD_0BAD, 0, 0, 1, 18));
        tx_full = 1'b0;
        check("tx_tmo_nopush", tx_pulses, 1);
        run(mk("tmo_stat", 0, 8'h18, 0, 32'h0000_0008, 1, 0, 2));
        check("tmo_irq", {30'd0, irq, int_tx}, 32'h2);
        run(mk("tmo_clr", 1, 8'h18, 32'h8, 0, 0, 0, 2));
        run(mk("tmo_clr_r", 0, 8'h18, 0, 32'h0, 1, 0, 2));

        // RX data arrives: interrupt and 4-cycle read
        rx_rdata = 32'hA5A5_0001;
        rx_empty = 1'b0;
        wait_cycles(2);
        check("rx_irq", {30'd0, irq, int_rx}, 32'h3);
        run(mk("rx_read", 0, 8'h04, 0, 32'hA5A5_0001, 1, 0, 4));
        check("rx_pops", rx_pulses, 1);
        run(mk("rx_stat", 0, 8'h18, 0, 32'h0000_0002, 1, 0, 2));
        run(mk("rx_clr", 1, 8'h18, 32'h2, 0, 0, 0, 2));
        check("rx_irq_clr", {30'd0, irq, int_rx}, 0);

        // New rx event lands in the same cycle as its W1C clear
        rx_empty = 1'b1;
        wait_cycles(2);
        fork
            run(mk("race_clr", 1, 8'h18, 32'h2, 0, 0, 0, 2));
            begin
                wait (PSELx && PENABLE);
                rx_empty = 1'b0;
            end
        join
        run(mk("race_keep", 0, 8'h18, 0, 32'h0000_0002, 1, 0, 2));
        check("race_irq", 32'(irq), 1);

        // Reset asserted while the RX read sits in RX_POP
        rx_rdata = 32'h1234_5678;
        @(posedge PCLK); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check("pop_pulse", rx_pulses, 2);
        check("pop_wait", 32'(PREADY), 0);
        PRESETn = 1'b0;
        #1;
        check("arst_pready", 32'(PREADY), 0);
        check("arst_prdata", PRDATA, 0);
        check("arst_cfg", {cfg, timeout}, 0);
        check("arst_irq", {29'd0, irq, int_tx, int_rx}, 0);
        check("arst_pulses", {30'd0, tx_wr_en, rx_rd_en}, 0);
        PSELx = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        wait_cycles(1);
        run(mk("post_rst_rx", 0, 8'h04, 0, 32'h1234_5678, 1, 0, 4));
        run(mk("post_rst_cfg", 0, 8'h08, 0, 32'h0, 1, 0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
